timer8_apb: RTL



---
 rtl/timer8_reg_pkg.sv | 53 +++++
 rtl/timer8_prescaler.sv | 43 ++++
 rtl/timer8_apb.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/timer8_reg_pkg.sv
// Register map, field layout and prescaler helper shared by the timer8 APB slave.
// Build option: define TIMER8_PSLVERR_EN to get error responses on reserved/RO accesses.
package timer8_reg_pkg;

    localparam logic [7:0] TDR_ADDR  = 8'h00;
    localparam logic [7:0] TCR_ADDR  = 8'h01;
    localparam logic [7:0] TSR_ADDR  = 8'h02;
    localparam logic [7:0] TIE_ADDR  = 8'h03;
    localparam logic [7:0] TCNT_ADDR = 8'h04;

    localparam int TCR_EN_BIT     = 0;
    localparam int TCR_LOAD_BIT   = 1;
    localparam int TCR_DN_BIT     = 2;
    localparam int TCR_CKS_LSB    = 3;
    localparam int TCR_CKS_MSB    = 4;
    localparam int TCR_DIV_EN_BIT = 5;
    localparam int TCR_W          = 6;

    localparam int TSR_OVF_BIT    = 0;
    localparam int TSR_UDF_BIT    = 1;
    localparam int TIE_OVF_IE_BIT = 0;
    localparam int TIE_UDF_IE_BIT = 1;
    localparam int FLAG_W         = 2;

    typedef enum logic [1:0] {
        CKS_DIV2  = 2'b00,
        CKS_DIV4  = 2'b01,
        CKS_DIV8  = 2'b10,
        CKS_DIV16 = 2'b11
    } cks_e;

    // Field order matches the TCR bit-index constants above (en is bit 0).
    typedef struct packed {
        logic div_en;
        cks_e cks;
        logic dn;
        logic load;
        logic en;
    } tcr_t;

    // Terminal prescaler value (N-1) for each divide setting.
    function automatic logic [3:0] cks_last(cks_e cks);
        logic [3:0] last;
        case (cks)
            CKS_DIV2:  last = 4'd1;
            CKS_DIV4:  last = 4'd3;
            CKS_DIV8:  last = 4'd7;
            default:   last = 4'd15;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/timer8_prescaler.sv
// Count-enable generator: ticks every cycle, or once every N cycles when dividing.
// Held at zero while disabled; restart realigns the period to the current edge.
module timer8_prescaler
    import timer8_reg_pkg::*;
(
    input  logic pclk,
    input  logic presetn,
    input  logic en,
    input  logic div_en,
    input  cks_e cks,
    input  logic restart,
    output logic tick
);

    logic [3:0] cnt_reg;
    logic [3:0] cnt_next;
    logic [3:0] last;

    assign last = cks_last(cks);

    // >= rather than == keeps the counter bounded even if it ever lands past the terminal value.
    assign tick = en & (~div_en | (cnt_reg >= last));

    always_comb begin
        cnt_next = cnt_reg;
        if (!en || restart) begin
            cnt_next = 4'd0;
        end else if (cnt_reg >= last) begin
            cnt_next = 4'd0;
        end else begin
            cnt_next = cnt_reg + 4'd1;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cnt_reg <= 4'd0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/timer8_apb.sv
// 8-bit up/down timer with APB register interface, sticky wrap flags and registered interrupts.
// Build option: TIMER8_PSLVERR_EN enables pslverr on reserved-address accesses and TCNT writes.
module timer8_apb
    import timer8_reg_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [7:0]        pwdata,
    output logic [7:0]        prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              tmr_ovf,
    output logic              tmr_udf
);

    logic [7:0]        tdr_reg;
    tcr_t              tcr_reg;
    logic [FLAG_W-1:0] ie_reg;
    logic [FLAG_W-1:0] flag_reg;
    logic [FLAG_W-1:0] flag_next;
    logic [FLAG_W-1:0] irq_reg;
    logic [7:0]        cnt_reg;
    logic [7:0]        cnt_next;
    logic [FLAG_W-1:0] set_vec;
    logic [FLAG_W-1:0] clr_vec;

    logic acc;
    logic wr;
    logic rd;
    logic sel_tdr;
    logic sel_tcr;
    logic sel_tsr;
    logic sel_tie;
    logic sel_tcnt;
    logic wr_tdr;
    logic wr_tcr;
    logic wr_tsr;
    logic wr_tie;
    tcr_t tcr_wdata;
    logic restart;
    logic tick;

    assign acc = psel & penable;
    assign wr  = acc & pwrite;
    assign rd  = acc & ~pwrite;

    assign sel_tdr  = (paddr == ADDR_W'(TDR_ADDR));
    assign sel_tcr  = (paddr == ADDR_W'(TCR_ADDR));
    assign sel_tsr  = (paddr == ADDR_W'(TSR_ADDR));
    assign sel_tie  = (paddr == ADDR_W'(TIE_ADDR));
    assign sel_tcnt = (paddr == ADDR_W'(TCNT_ADDR));

    assign wr_tdr = wr & sel_tdr;
    assign wr_tcr = wr & sel_tcr;
    assign wr_tsr = wr & sel_tsr;
    assign wr_tie = wr & sel_tie;

    assign tcr_wdata = tcr_t'(pwdata[TCR_W-1:0]);

    // Only timing-relevant fields realign the prescaler; toggling load or dn does not.
    assign restart = wr_tcr & ((tcr_wdata.en     != tcr_reg.en)  ||
                               (tcr_wdata.cks    != tcr_reg.cks) ||
                               (tcr_wdata.div_en != tcr_reg.div_en));

    timer8_prescaler u_prescaler (
        .pclk    (pclk),
        .presetn (presetn),
        .en      (tcr_reg.en),
        .div_en  (tcr_reg.div_en),
        .cks     (tcr_reg.cks),
        .restart (restart),
        .tick    (tick)
    );

    // Load has priority over counting and never raises a flag.
    always_comb begin
        cnt_next = cnt_reg;
        set_vec  = '0;
        if (tcr_reg.load) begin
            cnt_next = tdr_reg;
        end else if (tick) begin
            if (tcr_reg.dn) begin
                cnt_next = cnt_reg - 8'd1;
                set_vec[TSR_UDF_BIT] = (cnt_reg == 8'h00);
            end else begin
                cnt_next = cnt_reg + 8'd1;
                set_vec[TSR_OVF_BIT] = (cnt_reg == 8'hFF);
            end
        end
    end

    assign clr_vec = wr_tsr ? pwdata[FLAG_W-1:0] : '0;

    // A wrap on the same edge as a write-1-to-clear keeps the flag set.
    genvar gi;
    generate
        for (gi = 0; gi < FLAG_W; gi++) begin : g_flag
            assign flag_next[gi] = set_vec[gi] | (flag_reg[gi] & ~clr_vec[gi]);
        end
    endgenerate

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tdr_reg  <= 8'h00;
            tcr_reg  <= '0;
            ie_reg   <= '0;
            cnt_reg  <= 8'h00;
            flag_reg <= '0;
            irq_reg  <= '0;
        end else begin
            if (wr_tdr) begin
                tdr_reg <= pwdata;
            end
            if (wr_tcr) begin
                tcr_reg <= tcr_wdata;
            end
            if (wr_tie) begin
                ie_reg <= pwdata[FLAG_W-1:0];
            end
            cnt_reg  <= cnt_next;
            flag_reg <= flag_next;
            irq_reg  <= flag_reg & ie_reg;
        end
    end

    assign tmr_ovf = irq_reg[TIE_OVF_IE_BIT];
    assign tmr_udf = irq_reg[TIE_UDF_IE_BIT];
    assign pready  = 1'b1;

    always_comb begin
        prdata = 8'h00;
        if (rd) begin
            if (sel_tdr) begin
                prdata = tdr_reg;
            end else if (sel_tcr) begin
                prdata = {{(8 - TCR_W){1'b0}}, tcr_reg};
            end else if (sel_tsr) begin
                prdata = {{(8 - FLAG_W){1'b0}}, flag_reg};
            end else if (sel_tie) begin
                prdata = {{(8 - FLAG_W){1'b0}}, ie_reg};
            end else if (sel_tcnt) begin
                prdata = cnt_reg;
            end
        end
    end

`ifdef TIMER8_PSLVERR_EN
    logic reserved;
    assign reserved = ~(sel_tdr | sel_tcr | sel_tsr | sel_tie | sel_tcnt);
    assign pslverr  = acc & (reserved | (pwrite & sel_tcnt));
`else
    assign pslverr = 1'b0;
`endif

endmodule
